// File: rtl/mole_game_ctrl.sv
// Whack-a-mole sequencer: lights one LED per window, judges the switches, emits hit/miss pulses, tracks lives.
// Switch/start edges reach the FSM three clk edges after first sampling; all outputs are registered.
module mole_game_ctrl #(
  parameter int unsigned WIN_TICKS = 4,
  parameter int unsigned LIVES     = 3,
  parameter logic [7:0]  SEED      = 8'hB8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       start,
  input  logic [7:0] sw,
  output logic [7:0] led,
  output logic       hit,
  output logic       miss,
  output logic [1:0] lives,
  output logic       game_over
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_UP, S_HIT, S_MISS, S_OVER} state_t;

  state_t     state;
  logic [7:0] sw_s1, sw_s2, sw_s3, sw_rise;
  logic       st_s1, st_s2, st_s3, start_rise;
  logic [7:0] lfsr;
  logic [2:0] prev_idx;
  logic [2:0] pick;
  logic [3:0] timer;
  logic       wrong_rise;

  // Edge pulses are registered so the FSM only ever sees clean one-cycle rises.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sw_s1      <= '0;
      sw_s2      <= '0;
      sw_s3      <= '0;
      sw_rise    <= '0;
      st_s1      <= 1'b0;
      st_s2      <= 1'b0;
      st_s3      <= 1'b0;
      start_rise <= 1'b0;
    end else begin
      sw_s1      <= sw;
      sw_s2      <= sw_s1;
      sw_s3      <= sw_s2;
      sw_rise    <= sw_s2 & ~sw_s3;
      st_s1      <= start;
      st_s2      <= st_s1;
      st_s3      <= st_s2;
      start_rise <= st_s2 & ~st_s3;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) lfsr <= SEED;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Bump a repeated index so the same LED is never lit twice running.
  assign pick       = (lfsr[2:0] == prev_idx) ? lfsr[2:0] + 3'd1 : lfsr[2:0];
  assign wrong_rise = |(sw_rise & ~led);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= S_IDLE;
      led       <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      lives     <= '0;
      game_over <= 1'b0;
      prev_idx  <= 3'd7;
      timer     <= '0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        S_IDLE: begin
          led <= '0;
          if (start_rise) begin
            lives <= 2'(LIVES);
            state <= S_ARM;
          end
        end
        S_ARM: begin
          prev_idx <= pick;
          led      <= 8'd1 << pick;
          timer    <= 4'(WIN_TICKS);
          state    <= S_UP;
        end
        S_UP: begin
          if (tick && timer != 4'd0) timer <= timer - 4'd1;
          if (wrong_rise) begin
            miss  <= 1'b1;
            led   <= '0;
            state <= S_MISS;
          end else if (sw_rise[prev_idx]) begin
            hit   <= 1'b1;
            led   <= '0;
            state <= S_HIT;
          end else if (tick && timer == 4'd1) begin
            miss  <= 1'b1;
            led   <= '0;
            state <= S_MISS;
          end
        end
        S_HIT: state <= S_ARM;
        S_MISS: begin
          if (lives != 2'd0) lives <= lives - 2'd1;
          if (lives == 2'd1) begin
            led       <= 8'hFF;
            game_over <= 1'b1;
            state     <= S_OVER;
          end else begin
            state <= S_ARM;
          end
        end
        S_OVER: begin
          if (start_rise) begin
            lives     <= 2'(LIVES);
            led       <= '0;
            game_over <= 1'b0;
            state     <= S_ARM;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed vector table plus random soak for mole_game_ctrl; a reference LFSR predicts every mole.
module tb_mole_game_ctrl;

  localparam int A_HIT      = 0;
  localparam int A_WRONG    = 1;
  localparam int A_BOTH     = 2;
  localparam int A_TIMEOUT  = 3;
  localparam int A_LASTTICK = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] sw = '0;
  logic [7:0] led;
  logic       hit, miss, game_over;
  logic [1:0] lives;

  mole_game_ctrl #(.WIN_TICKS(4), .LIVES(3), .SEED(8'hB8)) dut (
    .clk(clk), .clr(clr), .tick(tick), .start(start), .sw(sw),
    .led(led), .hit(hit), .miss(miss), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hit_model = 0;
  int dut_hits = 0;
  int lives_m = 0;
  int cur_idx = 0;
  int prev_obs = -1;
  logic [2:0] prev_m = 3'd7;
  logic [7:0] lfsr_m, lfsr_last;
  logic [3:0] score [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

  // Reference LFSR; lfsr_last holds the value seen during the previous cycle (the ARM cycle on UP entry).
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      lfsr_m    <= 8'hB8;
      lfsr_last <= 8'hB8;
    end else begin
      lfsr_last <= lfsr_m;
      lfsr_m    <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
  end

  // Decimal score chain clocked by hit.
  always @(posedge hit) begin
    dut_hits = dut_hits + 1;
    for (int d = 0; d < 4; d++) begin
      if (score[d] == 4'd9) score[d] = 4'd0;
      else begin
        score[d] = score[d] + 4'd1;
        break;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_up(output int n);
    logic [2:0] raw, exp_idx;
    n = 0;
    while (!$onehot(led) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("mole_up_reached", 32'($onehot(led)), 32'd1);
    raw     = lfsr_last[2:0];
    exp_idx = (raw == prev_m) ? raw + 3'd1 : raw;
    prev_m  = exp_idx;
    chk("mole_led", led, 8'd1 << exp_idx);
    if (prev_obs >= 0) chk("mole_not_repeated", 32'(led == (8'd1 << prev_obs)), 32'd0);
    cur_idx = 0;
    for (int b = 0; b < 8; b++) if (led[b]) cur_idx = b;
    prev_obs = cur_idx;
  endtask

  task automatic run_action(input int act, output logic got_hit, output logic got_miss, output int lat);
    got_hit = 1'b0; got_miss = 1'b0; lat = 0;
    for (int i = 0; i < 40 && !got_hit && !got_miss; i++) begin
      tick = (act == A_TIMEOUT || act == A_LASTTICK) && i < 8 && (i % 2 == 0);
      sw = '0;
      if ((act == A_HIT || act == A_BOTH) && i == 0) sw[cur_idx] = 1'b1;
      if (act == A_BOTH && i == 0) sw[(cur_idx + 3) % 8] = 1'b1;
      if (act == A_WRONG && i == 0) sw[(cur_idx + 1) % 8] = 1'b1;
      if (act == A_LASTTICK && i == 3) sw[cur_idx] = 1'b1;
      @(negedge clk);
      lat = i + 1;
      got_hit = hit;
      got_miss = miss;
    end
    tick = 1'b0;
    sw = '0;
  endtask

  // From OVER with start held high: drop start, then give a fresh rise.
  task automatic restart_game(output int n);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    wait_up(n);
    lives_m = 3;
  endtask

  typedef struct {
    int         restart;
    int         arm_tick;
    int         act;
    logic       exp_hit;
    logic       exp_miss;
    int         exp_lat;
    logic [1:0] exp_lives;
    logic       exp_over;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int n, lat, found;
    logic gh, gm;

    vecs[0] = '{1, 0, A_HIT,      1'b1, 1'b0, 4, 2'd3, 1'b0};
    vecs[1] = '{0, 1, A_TIMEOUT,  1'b0, 1'b1, 7, 2'd2, 1'b0};
    vecs[2] = '{0, 0, A_LASTTICK, 1'b1, 1'b0, 7, 2'd2, 1'b0};
    vecs[3] = '{0, 0, A_BOTH,     1'b0, 1'b1, 4, 2'd1, 1'b0};
    vecs[4] = '{0, 0, A_HIT,      1'b1, 1'b0, 4, 2'd1, 1'b0};
    vecs[5] = '{0, 0, A_WRONG,    1'b0, 1'b1, 4, 2'd0, 1'b1};
    vecs[6] = '{2, 0, A_WRONG,    1'b0, 1'b1, 4, 2'd2, 1'b0};
    vecs[7] = '{0, 0, A_TIMEOUT,  1'b0, 1'b1, 7, 2'd1, 1'b0};
    vecs[8] = '{0, 0, A_BOTH,     1'b0, 1'b1, 4, 2'd0, 1'b1};

    #2 clr = 1'b1;
    @(negedge clk);
    chk("rst_led", led, 8'h00);
    chk("rst_hit", hit, 1'b0);
    chk("rst_miss", miss, 1'b0);
    chk("rst_lives", lives, 2'd0);
    chk("rst_game_over", game_over, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_led", led, 8'h00);

    foreach (vecs[v]) begin
      if (vecs[v].restart == 1) begin
        start = 1'b1;
        wait_up(n);
        chk("start_to_led_latency", n, 5);
        chk("start_lives", lives, 2'd3);
      end else if (vecs[v].restart == 2) begin
        repeat (10) @(negedge clk);
        chk("over_hold_game_over", game_over, 1'b1);
        chk("over_hold_led", led, 8'hFF);
        restart_game(n);
        chk("restart_latency", n, 5);
        chk("restart_lives", lives, 2'd3);
        chk("restart_game_over", game_over, 1'b0);
      end else begin
        if (vecs[v].arm_tick != 0) begin
          tick = 1'b1;
          @(negedge clk);
          tick = 1'b0;
        end
        wait_up(n);
        chk("next_mole_gap", n, (vecs[v].arm_tick != 0) ? 0 : 1);
      end
      run_action(vecs[v].act, gh, gm, lat);
      chk($sformatf("vec%0d_hit", v), gh, vecs[v].exp_hit);
      chk($sformatf("vec%0d_miss", v), gm, vecs[v].exp_miss);
      chk($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      if (vecs[v].exp_hit) hit_model++;
      @(negedge clk);
      chk($sformatf("vec%0d_pulse_width", v), hit | miss, 1'b0);
      chk($sformatf("vec%0d_lives", v), lives, vecs[v].exp_lives);
      chk($sformatf("vec%0d_game_over", v), game_over, vecs[v].exp_over);
      if (vecs[v].exp_over) chk($sformatf("vec%0d_over_led", v), led, 8'hFF);
    end

    lives_m = 0;
    for (int w = 0; w < 10000; w++) begin
      int act;
      if (lives_m == 0) restart_game(n);
      else wait_up(n);
      act = ($urandom_range(0, 15) == 0) ? A_WRONG : A_HIT;
      run_action(act, gh, gm, lat);
      chk("soak_hit", gh, act == A_HIT);
      chk("soak_miss", gm, act == A_WRONG);
      if (act == A_HIT) hit_model++;
      else lives_m--;
      @(negedge clk);
      chk("soak_lives", lives, lives_m[1:0]);
    end

    found = 0;
    for (int w = 0; w < 300 && found == 0; w++) begin
      if (lives_m == 0) restart_game(n);
      else wait_up(n);
      if (led == 8'h10) found = 1;
      else begin
        run_action(A_HIT, gh, gm, lat);
        chk("hunt_hit", gh, 1'b1);
        hit_model++;
        @(negedge clk);
      end
    end
    chk("hunt_led_10_found", found, 1);

    chk("hit_count", dut_hits, hit_model);
    chk("score_chain", score[3] * 1000 + score[2] * 100 + score[1] * 10 + score[0], hit_model % 10000);

    clr = 1'b1;
    #1;
    chk("clr_mid_up_led", led, 8'h00);
    chk("clr_mid_up_lives", lives, 2'd0);
    chk("clr_mid_up_game_over", game_over, 1'b0);
    chk("clr_mid_up_hit", hit, 1'b0);
    chk("clr_mid_up_miss", miss, 1'b0);
    repeat (3) @(negedge clk);
    chk("clr_hold_no_pulse", hit | miss, 1'b0);
    chk("clr_no_score_pulse", dut_hits, hit_model);
    clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_game_ctrl.md
# mole_game_ctrl

Game sequencer for the reaction-game top level: picks which of the 8 LEDs is lit, times each mole window off the divided game tick, and judges the 8 switches. It emits one-cycle `hit` pulses into the decimal score counter chain and tracks remaining lives until game over. It replaces the free-running LED/switch logic with one synchronous FSM in the `clk` domain.

## Interface
- `WIN_TICKS`, 4: number of `tick` pulses a mole stays lit (1..15).
- `LIVES`, 3: lives loaded at game start (1..3).
- `SEED`, 8'hB8: LFSR reset value (must be nonzero).

- `clk` in 1: system clock.
- `clr` in 1: asynchronous, active-high reset.
- `tick` in 1: one-`clk`-wide game time-base enable from the clock divider.
- `start` in 1: start/restart request, level, asynchronous to game.
- `sw` in 8: player switches, asynchronous.
- `led` out 8: LED drive; one-hot while a mole is up.
- `hit` out 1: one-cycle pulse per correct hit; drives score counter `clk`.
- `miss` out 1: one-cycle pulse per miss, wrong switch or timeout.
- `lives` out 2: remaining lives.
- `game_over` out 1: high in OVER.

## Operation
- Input conditioning:
  - `sw` and `start` each pass through 2-flop synchronizers plus a 3rd history flop.
  - `sw_rise[i]` = sync2 & ~sync3. `start_rise` is formed the same way.
  - Switch falls are ignored.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4, shift left, feedback into bit 0.
  - Advances every `clk` cycle when out of reset.
- Mole pick in ARM:
  - `idx = lfsr[2:0]`. If `idx == prev_idx`, use `idx+1` mod 8.
  - Store the result to `prev_idx`. Never the same LED twice in a row.
- States:
  - IDLE: `led=0`. On `start_rise`: `lives<=LIVES`, go to ARM.
  - ARM (1 cycle): pick mole, `timer<=WIN_TICKS`, go to UP.
  - UP: `led = 1<<idx`. On `tick`, `timer` decrements. Judge priority, highest first:
    1. any `sw_rise` on an unlit switch → MISS.
    2. `sw_rise[idx]` → HIT.
    3. `tick && timer==1` → MISS.
  - HIT (1 cycle): `hit=1`, `led=0`, go to ARM.
  - MISS (1 cycle): `miss=1`, `led=0`, `lives<=lives-1`. Go to OVER if `lives==1`, else ARM.
  - OVER: `led=8'hFF`, `game_over=1`. On `start_rise`: reload lives, go to ARM.
- `start_rise` in ARM/UP/HIT/MISS is ignored (no mid-game restart except via `clr`).
- `lives` saturates at 0 and never underflows.

## Timing
- Reset values (async `clr`, all outputs immediate):
  - outputs: `led=0`, `hit=0`, `miss=0`, `lives=0`, `game_over=0`.
  - internal: state IDLE, `lfsr=SEED`, `prev_idx=7`, `timer=0`, all sync flops 0.
- `clr` mid-game aborts to IDLE within the same cycle. No score pulse is emitted.
- Switch latency:
  - `sw[i]` first sampled high at edge k gives `sw_rise` during cycle k+2.
  - HIT/MISS state is entered at edge k+3, so `hit`/`miss` is high for cycle k+3..k+4.
- `start_rise` → ARM follows the same 3-edge latency. UP follows ARM by 1 edge, so the LED lights at edge k+4.
- Mole window is exactly `WIN_TICKS` tick pulses after entering UP. The window ends on the edge where the final tick is sampled.
- Boundary cases:
  - Timeout and correct hit in the same cycle → HIT.
  - Correct and wrong switch rising in the same cycle → MISS.
  - A `tick` coinciding with the ARM cycle is not counted.
- Each `hit` is exactly 1 cycle wide. At least 2 cycles separate consecutive `hit` pulses (HIT→ARM→UP).

## Test plan
- Reset: assert `clr` mid-UP with `led=8'h10` → same cycle: `led=0`, `lives=0`, `game_over=0`, no `hit`/`miss` pulse.
- Correct hit, `LIVES=3`:
  - Stimulus: `start` pulse, then raise the lit `sw[idx]`.
  - Required: exactly one 1-cycle `hit` 3 edges after sampling, `lives` stays 3, next mole `idx` differs from the previous one.
- Timeout, `WIN_TICKS=4`: no switch activity → `miss` exactly on the 4th tick after UP entry, `lives` 3→2, new mole lit 2 cycles later.
- Priority:
  - Raise `sw[idx]` and one other switch in the same cycle → `miss`, not `hit`.
  - Correct rise coinciding with the final tick → `hit`.
- Game over: 3 consecutive misses → `lives` 3→2→1→0, `led=8'hFF`, `game_over=1`. Holding `start` high does not restart; a fresh low→high restarts with `lives=3`.
- Soak:
  - Stimulus: 10 000 random windows, with the bench model mirroring the LFSR from `SEED=8'hB8`.
  - Required: LED always one-hot in UP, never the same index twice in a row, `hit` count matches the model, the score chain driven by `hit` reads the model count mod 10000.
